// File: rtl/prog_clock_divider.sv
// Programmable synchronous clock divider: tick enable every D cycles plus
// a 50% square wave at clk/(2*D), with boundary-aligned divisor reloads.
module prog_clock_divider #(
  parameter int WIDTH     = 26,
  parameter int RESET_DIV = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  output logic             tick,
  output logic             out_clk,
  output logic [WIDTH-1:0] div_active,
  output logic             pending,
  output logic [15:0]      tick_count
);

  localparam logic [WIDTH-1:0] RST_D = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] shadow;

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] shadow_d;
  logic [WIDTH-1:0] div_d;
  logic             pend_d;
  logic             tick_d;
  logic             out_d;
  logic [15:0]      tcnt_d;

  logic [WIDTH-1:0] div_clamp;
  logic [WIDTH-1:0] div_next;
  logic             at_end;
  logic             do_restart;
  logic             do_wrap;
  logic             do_step;
  logic             do_hold;

  assign div_clamp = (div_in == '0) ? ONE : div_in;
  assign at_end    = (cnt == div_active - ONE);

  // Divisor for the period about to start: a same-edge load beats shadow.
  assign div_next = div_load ? div_clamp :
                    pending  ? shadow    : div_active;

  assign do_restart = restart;
  assign do_wrap    = !restart && en && at_end;
  assign do_step    = !restart && en && !at_end;
  assign do_hold    = !restart && !en;

  always_comb begin
    cnt_d    = cnt;
    shadow_d = shadow;
    div_d    = div_active;
    pend_d   = pending;
    tick_d   = 1'b0;
    out_d    = out_clk;
    tcnt_d   = tick_count;
    unique case (1'b1)
      do_restart: begin
        cnt_d  = '0;
        out_d  = 1'b0;
        div_d  = div_next;
        pend_d = 1'b0;
      end
      do_wrap: begin
        cnt_d  = '0;
        tick_d = 1'b1;
        out_d  = ~out_clk;
        tcnt_d = tick_count + 16'd1;
        div_d  = div_next;
        pend_d = 1'b0;
      end
      do_step: begin
        cnt_d = cnt + ONE;
        if (div_load) begin
          shadow_d = div_clamp;
          pend_d   = 1'b1;
        end
      end
      do_hold: begin
        if (div_load) begin
          shadow_d = div_clamp;
          pend_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      div_active <= RST_D;
      shadow     <= RST_D;
      pending    <= 1'b0;
      tick       <= 1'b0;
      out_clk    <= 1'b0;
      tick_count <= '0;
    end else begin
      cnt        <= cnt_d;
      div_active <= div_d;
      shadow     <= shadow_d;
      pending    <= pend_d;
      tick       <= tick_d;
      out_clk    <= out_d;
      tick_count <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider: directed scenarios with
// literal expectations plus a randomized run against a period-level model.
module tb_prog_clock_divider;

  localparam int W = 26;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         restart = 1'b0;
  logic         div_load = 1'b0;
  logic [W-1:0] div_in = '0;
  logic         tick;
  logic         out_clk;
  logic [W-1:0] div_active;
  logic         pending;
  logic [15:0]  tick_count;

  int n_pass = 0;
  int n_total = 0;
  bit check_on = 1'b0;

  prog_clock_divider #(.WIDTH(W), .RESET_DIV(512)) dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .div_load(div_load), .div_in(div_in), .tick(tick),
    .out_clk(out_clk), .div_active(div_active),
    .pending(pending), .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: position within the current period, the period length in use,
  // and a divisor waiting for the next period to begin.
  int  m_pos, m_len, m_wait_len, m_tc;
  bit  m_waiting, m_tick, m_out;

  function automatic int clampf(input logic [W-1:0] x);
    return (x == 0) ? 1 : int'(x);
  endfunction

  always @(posedge clk) begin
    int next_len;
    next_len = div_load ? clampf(div_in) :
               (m_waiting ? m_wait_len : m_len);
    m_tick = 1'b0;
    if (rst) begin
      m_pos = 0; m_len = 512; m_wait_len = 512;
      m_waiting = 0; m_out = 0; m_tc = 0;
    end else if (restart) begin
      m_pos = 0; m_out = 0;
      m_len = next_len; m_waiting = 0;
    end else if (en && m_pos + 1 == m_len) begin
      m_pos = 0; m_tick = 1; m_out = !m_out;
      m_tc = (m_tc + 1) % 65536;
      m_len = next_len; m_waiting = 0;
    end else begin
      if (en) m_pos++;
      if (div_load) begin
        m_wait_len = clampf(div_in);
        m_waiting = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_on) begin
      chk("tick", tick, m_tick);
      chk("out_clk", out_clk, m_out);
      chk("div_active", div_active, m_len);
      chk("pending", pending, m_waiting);
      chk("tick_count", tick_count, m_tc);
    end
  end

  task automatic edge1();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_tick(input string name, input int exp);
    int n = 0;
    do begin
      edge1();
      n++;
    end while (!tick && n < 5000);
    chk(name, n, exp);
  endtask

  initial begin
    int tick_edges[$];
    bit prev_out;

    // Reset default
    edge1();
    check_on = 1'b1;
    chk("rst_div_active", div_active, 512);
    chk("rst_tick_count", tick_count, 0);
    rst = 1'b0;
    en = 1'b1;
    for (int k = 1; k <= 2100; k++) begin
      edge1();
      if (tick) tick_edges.push_back(k);
      if (k == 600) chk("out_clk_hi_600", out_clk, 1);
      if (k == 1100) chk("out_clk_lo_1100", out_clk, 0);
      if (k == 1600) chk("out_clk_hi_1600", out_clk, 1);
    end
    chk("n_ticks", tick_edges.size(), 4);
    for (int i = 0; i < tick_edges.size() && i < 4; i++)
      chk("tick_edge", tick_edges[i], 512 * (i + 1));
    chk("tick_count_2100", tick_count, 4);

    // Mid-period load
    restart = 1; div_load = 1; div_in = 8;
    edge1();
    restart = 0; div_load = 0;
    chk("d8", div_active, 8);
    edge1(); edge1(); edge1();
    div_load = 1; div_in = 3;
    edge1();
    div_load = 0;
    chk("pend_mid", pending, 1);
    chk("d_still8", div_active, 8);
    wait_tick("old_period_rest", 4);
    chk("pend_cleared", pending, 0);
    chk("d3", div_active, 3);
    wait_tick("period3_a", 3);
    wait_tick("period3_b", 3);

    // Boundary load of zero
    edge1(); edge1();
    div_load = 1; div_in = 0;
    edge1();
    div_load = 0;
    chk("bnd_tick", tick, 1);
    chk("bnd_d1", div_active, 1);
    chk("bnd_pend", pending, 0);
    prev_out = out_clk;
    for (int i = 0; i < 5; i++) begin
      edge1();
      chk("d1_tick", tick, 1);
      chk("d1_toggle", out_clk, !prev_out);
      prev_out = out_clk;
    end

    // Enable gating
    restart = 1; div_load = 1; div_in = 5;
    edge1();
    restart = 0; div_load = 0;
    edge1(); edge1();
    en = 0;
    prev_out = out_clk;
    for (int i = 0; i < 10; i++) begin
      edge1();
      chk("gated_tick", tick, 0);
      chk("gated_out", out_clk, prev_out);
    end
    en = 1;
    wait_tick("gated_resume", 3);

    // Restart plus load mid-period
    edge1(); edge1();
    restart = 1; div_load = 1; div_in = 6;
    edge1();
    restart = 0; div_load = 0;
    chk("rl_out", out_clk, 0);
    chk("rl_d6", div_active, 6);
    chk("rl_tick", tick, 0);
    wait_tick("rl_period", 6);

    // Reset with a pending load
    edge1();
    div_load = 1; div_in = 20;
    edge1();
    div_load = 0;
    chk("pre_rst_pend", pending, 1);
    rst = 1;
    edge1();
    rst = 0;
    chk("rr_pend", pending, 0);
    chk("rr_d", div_active, 512);
    chk("rr_tc", tick_count, 0);
    chk("rr_out", out_clk, 0);
    chk("rr_tick", tick, 0);

    // Randomized traffic against the model
    restart = 1; div_load = 1; div_in = 4;
    edge1();
    for (int i = 0; i < 4000; i++) begin
      en       = ($urandom_range(99) < 80);
      restart  = ($urandom_range(99) < 2);
      div_load = ($urandom_range(99) < 8);
      div_in   = W'($urandom_range(12));
      rst      = ($urandom_range(999) < 3);
      edge1();
    end
    rst = 0; restart = 0; div_load = 0; en = 0;
    edge1();

    @(negedge clk);
    check_on = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
